// File: rtl/tt_check_pkg.sv
// Shared types and defaults for the truth-table sweep checker.
package tt_check_pkg;

    localparam int          TT_N_IN      = 5;
    localparam logic [31:0] TT_REF_TABLE = 32'hD5BA8AE9;
    localparam int          TT_HOLD_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } tt_state_e;

endpackage

// File: rtl/tt_channel_check.sv
// One checker channel: mismatch mask, pass flag and, with TT_ERR_CNT_EN, a saturating mismatch count.
module tt_channel_check
    import tt_check_pkg::*;
#(
    parameter int N_IN = TT_N_IN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 sample_i,
    input  logic                 last_i,
    input  logic [N_IN-1:0]      arg_i,
    input  logic                 exp_i,
    input  logic                 f_i,
    output logic [2**N_IN-1:0]   mask_o,
    output logic                 pass_o
`ifdef TT_ERR_CNT_EN
    ,
    output logic [N_IN:0]        cnt_o
`endif
);

    localparam int DEPTH = 2**N_IN;

    logic             miss;
    logic [DEPTH-1:0] mask_q, mask_d;
    logic             pass_q, pass_d;

    assign miss = f_i ^ exp_i;

    // pass is resolved on the last sample edge so it is valid alongside done
    always_comb begin
        mask_d = mask_q;
        pass_d = pass_q;
        if (clear_i) begin
            mask_d = '0;
            pass_d = 1'b0;
        end else if (sample_i) begin
            mask_d[arg_i] = miss;
            if (last_i) begin
                pass_d = (mask_d == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
            pass_q <= 1'b0;
        end else begin
            mask_q <= mask_d;
            pass_q <= pass_d;
        end
    end

    assign mask_o = mask_q;
    assign pass_o = pass_q;

`ifdef TT_ERR_CNT_EN
    localparam logic [N_IN:0] CNT_MAX = (N_IN+1)'(DEPTH);

    logic [N_IN:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (sample_i && miss && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweep-and-check engine: walks every argument, samples two function outputs against a reference table.
// Optional mismatch counters are enabled by defining TT_ERR_CNT_EN.
//   state    | meaning
//   ST_IDLE  | arg_o held at 0, waiting for start; previous results held
//   ST_SWEEP | argument held HOLD cycles, sampled on the last, then advanced
//   ST_DONE  | one-cycle done pulse, pass flags valid, back to idle
module tt_sweep_checker
    import tt_check_pkg::*;
#(
    parameter int                  N_IN      = TT_N_IN,
    parameter logic [2**N_IN-1:0]  REF_TABLE = TT_REF_TABLE,
    parameter int                  HOLD      = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [N_IN-1:0]      arg_o,
    input  logic                 f1_i,
    input  logic                 f2_i,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   err_mask1,
    output logic [2**N_IN-1:0]   err_mask2,
    output logic                 pass1,
    output logic                 pass2
`ifdef TT_ERR_CNT_EN
    ,
    output logic [N_IN:0]        err_cnt1,
    output logic [N_IN:0]        err_cnt2
`endif
);

    localparam logic [TT_HOLD_W-1:0] HOLD_LAST = TT_HOLD_W'(HOLD - 1);

    tt_state_e              state_q, state_d;
    logic [N_IN-1:0]        arg_q, arg_d;
    logic [TT_HOLD_W-1:0]   hold_q, hold_d;
    logic                   clear;
    logic                   sample;
    logic                   last;
    logic                   exp_bit;

    assign clear  = (state_q == ST_IDLE) && start;
    assign sample = (state_q == ST_SWEEP) && (hold_q == HOLD_LAST);
    assign last   = (arg_q == '1);
    // table is MSB-first: argument i maps to bit DEPTH-1-i, i.e. the inverted index
    assign exp_bit = REF_TABLE[~arg_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            arg_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            arg_q   <= arg_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        arg_d   = arg_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                arg_d = '0;
                if (start) begin
                    state_d = ST_SWEEP;
                    hold_d  = '0;
                end
            end
            ST_SWEEP: begin
                if (sample) begin
                    hold_d = '0;
                    arg_d  = arg_q + 1'b1;
                    if (last) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                arg_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_SWEEP: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    assign arg_o = arg_q;

    tt_channel_check #(.N_IN(N_IN)) u_ch1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (clear),
        .sample_i (sample),
        .last_i   (last),
        .arg_i    (arg_q),
        .exp_i    (exp_bit),
        .f_i      (f1_i),
        .mask_o   (err_mask1),
        .pass_o   (pass1)
`ifdef TT_ERR_CNT_EN
        ,
        .cnt_o    (err_cnt1)
`endif
    );

    tt_channel_check #(.N_IN(N_IN)) u_ch2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (clear),
        .sample_i (sample),
        .last_i   (last),
        .arg_i    (arg_q),
        .exp_i    (exp_bit),
        .f_i      (f2_i),
        .mask_o   (err_mask2),
        .pass_o   (pass2)
`ifdef TT_ERR_CNT_EN
        ,
        .cnt_o    (err_cnt2)
`endif
    );

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: a HOLD=1 instance and a HOLD=3 instance driven by function models.
module tb_tt_sweep_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start_a = 1'b0;
    logic [4:0]  arg_a;
    logic        f1_a, f2_a, busy_a, done_a, pass1_a, pass2_a;
    logic [31:0] mask1_a, mask2_a;

    logic        start_b = 1'b0;
    logic [4:0]  arg_b;
    logic        f1_b, f2_b, busy_b, done_b, pass1_b, pass2_b;
    logic [31:0] mask1_b, mask2_b;

`ifdef TT_ERR_CNT_EN
    logic [5:0]  cnt1_a, cnt2_a, cnt1_b, cnt2_b;
`endif

    // 0 = ideal, 1 = stuck at 0, 2 = stuck at 1, 3 = inverted only at argument 5
    int mode_a1 = 0, mode_a2 = 0, mode_b1 = 0, mode_b2 = 0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic fmodel(input int mode, input logic [4:0] arg);
        logic [31:0] tbl;
        logic        b;
        tbl = 32'hD5BA8AE9;
        b   = tbl[31 - arg];
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return (arg == 5'd5) ? ~b : b;
            default: return b;
        endcase
    endfunction

    always_comb f1_a = fmodel(mode_a1, arg_a);
    always_comb f2_a = fmodel(mode_a2, arg_a);
    always_comb f1_b = fmodel(mode_b1, arg_b);
    always_comb f2_b = fmodel(mode_b2, arg_b);

    tt_sweep_checker #(.HOLD(1)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_a),
        .arg_o     (arg_a),
        .f1_i      (f1_a),
        .f2_i      (f2_a),
        .busy      (busy_a),
        .done      (done_a),
        .err_mask1 (mask1_a),
        .err_mask2 (mask2_a),
        .pass1     (pass1_a),
        .pass2     (pass2_a)
`ifdef TT_ERR_CNT_EN
        ,
        .err_cnt1  (cnt1_a),
        .err_cnt2  (cnt2_a)
`endif
    );

    tt_sweep_checker #(.HOLD(3)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_b),
        .arg_o     (arg_b),
        .f1_i      (f1_b),
        .f2_i      (f2_b),
        .busy      (busy_b),
        .done      (done_b),
        .err_mask1 (mask1_b),
        .err_mask2 (mask2_b),
        .pass1     (pass1_b),
        .pass2     (pass2_b)
`ifdef TT_ERR_CNT_EN
        ,
        .err_cnt1  (cnt1_b),
        .err_cnt2  (cnt2_b)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulses start for one cycle; lat counts the accept cycle as 1 and stops on done (bounded).
    task automatic sweep_a(output int lat);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        lat = 1;
        while (!done_a && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_reset_a(input string pfx);
        check_val({pfx, "_arg"},   64'(arg_a),   64'h0);
        check_val({pfx, "_busy"},  64'(busy_a),  64'h0);
        check_val({pfx, "_done"},  64'(done_a),  64'h0);
        check_val({pfx, "_mask1"}, 64'(mask1_a), 64'h0);
        check_val({pfx, "_mask2"}, 64'(mask2_a), 64'h0);
        check_val({pfx, "_pass1"}, 64'(pass1_a), 64'h0);
        check_val({pfx, "_pass2"}, 64'(pass2_a), 64'h0);
`ifdef TT_ERR_CNT_EN
        check_val({pfx, "_cnt1"},  64'(cnt1_a),  64'h0);
        check_val({pfx, "_cnt2"},  64'(cnt2_a),  64'h0);
`endif
    endtask

    initial begin
        int lat;
        int bad;
        int dcnt;
        int n;

        repeat (3) @(posedge clk);
        #1;
        check_reset_a("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ideal models, HOLD=1
        sweep_a(lat);
        check_val("ideal_latency", 64'(lat),     64'd33);
        check_val("ideal_busy",    64'(busy_a),  64'h0);
        check_val("ideal_mask1",   64'(mask1_a), 64'h0);
        check_val("ideal_mask2",   64'(mask2_a), 64'h0);
        check_val("ideal_pass1",   64'(pass1_a), 64'h1);
        check_val("ideal_pass2",   64'(pass2_a), 64'h1);
`ifdef TT_ERR_CNT_EN
        check_val("ideal_cnt1",    64'(cnt1_a),  64'h0);
        check_val("ideal_cnt2",    64'(cnt2_a),  64'h0);
`endif
        @(posedge clk); #1;
        check_val("ideal_done_one_cycle", 64'(done_a), 64'h0);

        // channel 1 stuck at 0: bit i of the mask is table bit 31-i (bit-reversed table)
        mode_a1 = 1;
        sweep_a(lat);
        check_val("s0_mask1", 64'(mask1_a), 64'h97515DAB);
        check_val("s0_pass1", 64'(pass1_a), 64'h0);
        check_val("s0_mask2", 64'(mask2_a), 64'h0);
        check_val("s0_pass2", 64'(pass2_a), 64'h1);
`ifdef TT_ERR_CNT_EN
        check_val("s0_cnt1",  64'(cnt1_a),  64'd18);
        check_val("s0_cnt2",  64'(cnt2_a),  64'd0);
`endif
        @(posedge clk); #1;

        // channel 2 stuck at 1
        mode_a1 = 0;
        mode_a2 = 2;
        sweep_a(lat);
        check_val("s1_mask2", 64'(mask2_a), 64'h68AEA254);
        check_val("s1_pass2", 64'(pass2_a), 64'h0);
        check_val("s1_mask1", 64'(mask1_a), 64'h0);
        check_val("s1_pass1", 64'(pass1_a), 64'h1);
`ifdef TT_ERR_CNT_EN
        check_val("s1_cnt2",  64'(cnt2_a),  64'd14);
        check_val("s1_cnt1",  64'(cnt1_a),  64'd0);
`endif
        @(posedge clk); #1;
        check_val("s1_mask2_held", 64'(mask2_a), 64'h68AEA254);

        // HOLD=3, channel 1 wrong only at argument 5; arg must equal floor(k/3) k edges after accept
        mode_b1 = 3;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        lat = 1;
        bad = 0;
        while (!done_b && lat < 400) begin
            if (arg_b != 5'((lat - 1) / 3)) bad++;
            @(posedge clk); #1;
            lat++;
        end
        check_val("h3_latency",   64'(lat),     64'd97);
        check_val("h3_arg_steps", 64'(bad),     64'd0);
        check_val("h3_mask1",     64'(mask1_b), 64'h00000020);
        check_val("h3_pass1",     64'(pass1_b), 64'h0);
        check_val("h3_mask2",     64'(mask2_b), 64'h0);
        check_val("h3_pass2",     64'(pass2_b), 64'h1);
`ifdef TT_ERR_CNT_EN
        check_val("h3_cnt1",      64'(cnt1_b),  64'd1);
`endif
        @(posedge clk); #1;

        // reset mid-sweep with faulty channels, then a clean ideal sweep
        mode_a1 = 1;
        mode_a2 = 2;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        n = 0;
        while (arg_a != 5'd12 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("mid_reached_arg12", 64'(arg_a), 64'd12);
        check_val("mid_busy_before",   64'(busy_a), 64'h1);
        rst_n = 1'b0;
        #1;
        check_reset_a("midrst");
        @(posedge clk); #1;
        check_val("midrst_no_done", 64'(done_a), 64'h0);
        rst_n = 1'b1;
        mode_a1 = 0;
        mode_a2 = 0;
        @(posedge clk); #1;
        check_val("post_rst_idle", 64'(busy_a), 64'h0);
        sweep_a(lat);
        check_val("post_rst_latency", 64'(lat),     64'd33);
        check_val("post_rst_mask1",   64'(mask1_a), 64'h0);
        check_val("post_rst_mask2",   64'(mask2_a), 64'h0);
        check_val("post_rst_pass1",   64'(pass1_a), 64'h1);
        check_val("post_rst_pass2",   64'(pass2_a), 64'h1);
        @(posedge clk); #1;

        // start held through sweep and DONE: one done pulse, restart only from IDLE
        start_a = 1'b1;
        dcnt = 0;
        for (int k = 0; k <= 33; k++) begin
            @(posedge clk); #1;
            if (done_a) dcnt++;
        end
        check_val("held_done_pulses", 64'(dcnt),   64'd1);
        check_val("held_idle_gap",    64'(busy_a), 64'h0);
        @(posedge clk); #1;
        start_a = 1'b0;
        check_val("held_restart", 64'(busy_a), 64'h1);
        n = 0;
        while (!done_a && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("held_second_done", 64'(done_a),  64'h1);
        check_val("held_second_pass", 64'(pass1_a), 64'h1);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
